// File: rtl/srt_div_arbiter_if.sv
// Requester, SRT datapath and response signals of srt_div_arbiter.
// slave = arbiter side, master = requesters/datapath/response consumer side.
interface srt_div_arbiter_if;
  logic [3:0]  req;
  logic [23:0] req_n;
  logic [23:0] req_d;
  logic [3:0]  gnt;
  logic        div_start;
  logic [5:0]  div_n;
  logic [5:0]  div_d;
  logic        div_done;
  logic [5:0]  div_q;
  logic [3:0]  div_r;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [5:0]  resp_q;
  logic [3:0]  resp_r;
  logic        resp_err;

  modport slave (
    input  req, req_n, req_d, div_done, div_q, div_r, resp_ready,
    output gnt, div_start, div_n, div_d, resp_valid, resp_id, resp_q, resp_r, resp_err
  );

  modport master (
    output req, req_n, req_d, div_done, div_q, div_r, resp_ready,
    input  gnt, div_start, div_n, div_d, resp_valid, resp_id, resp_q, resp_r, resp_err
  );
endinterface

// File: rtl/srt_div_arbiter.sv
// Round-robin arbiter sharing one SRT radix-4 divider among four requesters.
// Define SRT_DIV_ARB_TIMEOUT_EN to abort a WAIT lasting 16 cycles with resp_err.
module srt_div_arbiter (
    input logic clk,
    input logic resetn,
    srt_div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] cur_id;
    logic [3:0] gnt_r;
    logic       div_start_r;
    logic [5:0] div_n_r;
    logic [5:0] div_d_r;
    logic       resp_valid_r;
    logic [1:0] resp_id_r;
    logic [5:0] resp_q_r;
    logic [3:0] resp_r_r;
    logic       resp_err_r;
`ifdef SRT_DIV_ARB_TIMEOUT_EN
    logic [4:0] tmo_cnt;
`endif

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] idx;
    logic [5:0] win_n;
    logic [5:0] win_d;
    logic       win_legal;

    // Search starts just above the last served requester and wraps back to it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        win_n = '0;
        win_d = '0;
        case (win_idx)
            2'd0: begin win_n = bus.req_n[5:0];   win_d = bus.req_d[5:0];   end
            2'd1: begin win_n = bus.req_n[11:6];  win_d = bus.req_d[11:6];  end
            2'd2: begin win_n = bus.req_n[17:12]; win_d = bus.req_d[17:12]; end
            default: begin win_n = bus.req_n[23:18]; win_d = bus.req_d[23:18]; end
        endcase
        win_legal = (win_d[5:2] >= 4'd4) && (win_d[5:2] <= 4'd8);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            ptr          <= 2'd3;
            cur_id       <= '0;
            gnt_r        <= '0;
            div_start_r  <= 1'b0;
            div_n_r      <= '0;
            div_d_r      <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_q_r     <= '0;
            resp_r_r     <= '0;
            resp_err_r   <= 1'b0;
`ifdef SRT_DIV_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        // Grant and start are registered here so they appear in ISSUE.
                        cur_id      <= win_idx;
                        div_n_r     <= win_n;
                        div_d_r     <= win_d;
                        gnt_r       <= 4'b0001 << win_idx;
                        div_start_r <= win_legal;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_r       <= '0;
                    div_start_r <= 1'b0;
                    if (div_start_r) begin
                        state <= WAIT;
`ifdef SRT_DIV_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        resp_valid_r <= 1'b1;
                        resp_id_r    <= cur_id;
                        resp_q_r     <= '0;
                        resp_r_r     <= '0;
                        resp_err_r   <= 1'b1;
                        state        <= RESP;
                    end
                end
                WAIT: begin
`ifdef SRT_DIV_ARB_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 5'd1;
`endif
                    if (bus.div_done) begin
                        resp_valid_r <= 1'b1;
                        resp_id_r    <= cur_id;
                        resp_q_r     <= bus.div_q;
                        resp_r_r     <= bus.div_r;
                        resp_err_r   <= 1'b0;
                        state        <= RESP;
                    end
`ifdef SRT_DIV_ARB_TIMEOUT_EN
                    // A count of 15 here means this is the 16th WAIT cycle.
                    else if (tmo_cnt == 5'd15) begin
                        resp_valid_r <= 1'b1;
                        resp_id_r    <= cur_id;
                        resp_q_r     <= '0;
                        resp_r_r     <= '0;
                        resp_err_r   <= 1'b1;
                        state        <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        ptr          <= resp_id_r;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.div_start  = div_start_r;
    assign bus.div_n      = div_n_r;
    assign bus.div_d      = div_d_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_q     = resp_q_r;
    assign bus.resp_r     = resp_r_r;
    assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_srt_div_arbiter.sv
// Scoreboard bench for srt_div_arbiter with a behavioural SRT datapath stub.
module tb_srt_div_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    srt_div_arbiter_if bus();

    srt_div_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic       start;
        logic [5:0] n;
        logic [5:0] d;
    } gnt_t;

    typedef struct {
        logic [1:0] id;
        logic [5:0] q;
        logic [3:0] r;
        logic       err;
    } resp_t;

    gnt_t  exp_gnt[$];
    resp_t exp_resp[$];

    int checks = 0;
    int passed = 0;
    int n_resp = 0;
    logic dp_enable = 1'b1;
    int   dp_delay  = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [3:0] g, input logic s, input logic [5:0] n, input logic [5:0] d);
        gnt_t e;
        e.gnt = g; e.start = s; e.n = n; e.d = d;
        exp_gnt.push_back(e);
    endtask

    task automatic push_resp(input logic [1:0] id, input logic [5:0] q, input logic [3:0] r, input logic err);
        resp_t e;
        e.id = id; e.q = q; e.r = r; e.err = err;
        exp_resp.push_back(e);
    endtask

    task automatic wait_resp(input int target, input int budget);
        for (int c = 0; c < budget && n_resp < target; c++) step();
        check("resp_count", n_resp, target);
    endtask

    // Datapath stub: answers each div_start after dp_delay edges.
    initial begin
        logic [5:0] n, d;
        bus.div_done = 1'b0;
        bus.div_q    = '0;
        bus.div_r    = '0;
        forever begin
            @(negedge clk);
            if (resetn && bus.div_start && dp_enable) begin
                n = bus.div_n;
                d = bus.div_d;
                repeat (dp_delay) @(posedge clk);
                #1;
                bus.div_done = 1'b1;
                bus.div_q    = n / d;
                bus.div_r    = 4'(n % d);
                @(posedge clk);
                #1;
                bus.div_done = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants or hands over a response.
    initial begin
        gnt_t  g;
        resp_t r;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus.gnt != 4'b0000 || bus.div_start) begin
                    if (exp_gnt.size() == 0) begin
                        check("unexpected_gnt", {27'd0, bus.div_start, bus.gnt}, 32'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        check("gnt", bus.gnt, g.gnt);
                        check("div_start", bus.div_start, g.start);
                        if (g.start) begin
                            check("div_n", bus.div_n, g.n);
                            check("div_d", bus.div_d, g.d);
                        end
                    end
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    if (exp_resp.size() == 0) begin
                        check("unexpected_resp", bus.resp_valid, 1'b0);
                    end else begin
                        r = exp_resp.pop_front();
                        check("resp_id", bus.resp_id, r.id);
                        check("resp_q", bus.resp_q, r.q);
                        check("resp_r", bus.resp_r, r.r);
                        check("resp_err", bus.resp_err, r.err);
                    end
                    n_resp++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int q_tab[4] = '{2, 3, 3, 1};
        int r_tab[4] = '{0, 2, 0, 2};
        int n_tab[4] = '{40, 50, 63, 35};
        int d_tab[4] = '{20, 16, 21, 33};
        int grants;

        bus.req        = '0;
        bus.req_n      = '0;
        bus.req_d      = '0;
        bus.resp_ready = 1'b1;
        resetn = 1'b0;
        step();
        step();
        check("rst_gnt", bus.gnt, 0);
        check("rst_div_start", bus.div_start, 0);
        check("rst_div_n", bus.div_n, 0);
        check("rst_div_d", bus.div_d, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_resp_q", bus.resp_q, 0);
        check("rst_resp_r", bus.resp_r, 0);
        check("rst_resp_err", bus.resp_err, 0);
        resetn = 1'b1;

        // Single request: 40 / 20
        bus.req   = 4'b0001;
        bus.req_n = 24'd40;
        bus.req_d = 24'd20;
        push_job(4'b0001, 1'b1, 6'd40, 6'd20);
        push_resp(2'd0, 6'd2, 4'd0, 1'b0);
        step();
        check("single_gnt_latency", bus.gnt, 4'b0001);
        check("single_start_latency", bus.div_start, 1);
        bus.req = '0;
        step(); step(); step();
        check("single_valid_early", bus.resp_valid, 0);
        step();
        check("single_valid_after_done", bus.resp_valid, 1);
        step();

        // Illegal divisor on requester 2
        bus.req   = 4'b0100;
        bus.req_n = 24'd13 << 12;
        bus.req_d = 24'd8 << 12;
        push_job(4'b0100, 1'b0, 6'd0, 6'd0);
        push_resp(2'd2, 6'd0, 4'd0, 1'b1);
        step();
        check("illegal_gnt", bus.gnt, 4'b0100);
        check("illegal_no_start", bus.div_start, 0);
        check("illegal_valid_early", bus.resp_valid, 0);
        bus.req = '0;
        step();
        check("illegal_valid_t2", bus.resp_valid, 1);
        step();

        // Round robin with all four requesting
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        dp_delay  = 2;
        bus.req_n = {6'd35, 6'd63, 6'd50, 6'd40};
        bus.req_d = {6'd33, 6'd21, 6'd16, 6'd20};
        for (int k = 0; k < 5; k++) begin
            push_job(4'b0001 << order[k], 1'b1, 6'(n_tab[order[k]]), 6'(d_tab[order[k]]));
            push_resp(2'(order[k]), 6'(q_tab[order[k]]), 4'(r_tab[order[k]]), 1'b0);
        end
        bus.req = 4'b1111;
        grants = 0;
        for (int c = 0; c < 200 && grants < 5; c++) begin
            step();
            if (bus.gnt != 4'b0000) grants++;
        end
        bus.req = '0;
        check("rr_grant_count", grants, 5);
        wait_resp(7, 100);
        step(); step();

        // Backpressure on requester 1: 45 / 18 = 2 r 9
        dp_delay = 3;
        bus.resp_ready = 1'b0;
        bus.req_n = 24'd45 << 6;
        bus.req_d = 24'd18 << 6;
        push_job(4'b0010, 1'b1, 6'd45, 6'd18);
        push_resp(2'd1, 6'd2, 4'd9, 1'b0);
        bus.req = 4'b0010;
        for (int c = 0; c < 50 && !bus.resp_valid; c++) step();
        check("bp_valid", bus.resp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", bus.resp_valid, 1);
            check("bp_hold_id", bus.resp_id, 1);
            check("bp_hold_q", bus.resp_q, 2);
            check("bp_hold_r", bus.resp_r, 9);
            check("bp_hold_err", bus.resp_err, 0);
            check("bp_no_gnt", bus.gnt, 0);
        end
        push_job(4'b0010, 1'b1, 6'd45, 6'd18);
        push_resp(2'd1, 6'd2, 4'd9, 1'b0);
        bus.resp_ready = 1'b1;
        step();
        check("bp_idle_valid", bus.resp_valid, 0);
        check("bp_idle_gnt", bus.gnt, 0);
        step();
        check("bp_regrant", bus.gnt, 4'b0010);
        bus.req = '0;
        wait_resp(9, 100);
        step(); step();

        // Reset while WAIT, then a stale div_done
        dp_enable = 1'b0;
        bus.req_n = 24'd40;
        bus.req_d = 24'd20;
        push_job(4'b0001, 1'b1, 6'd40, 6'd20);
        bus.req = 4'b0001;
        step();
        check("abort_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        step(); step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        bus.div_done = 1'b1;
        bus.div_q    = 6'd5;
        bus.div_r    = 4'd3;
        step();
        bus.div_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_valid", bus.resp_valid, 0);
            check("abort_outputs_zero",
                  {bus.gnt, bus.div_start, bus.div_n, bus.div_d, bus.resp_id, bus.resp_q, bus.resp_r, bus.resp_err}, 0);
        end

`ifdef SRT_DIV_ARB_TIMEOUT_EN
        // No div_done: error response after 16 WAIT cycles
        push_job(4'b0001, 1'b1, 6'd40, 6'd20);
        push_resp(2'd0, 6'd0, 4'd0, 1'b1);
        bus.req = 4'b0001;
        step();
        check("tmo_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        for (int k = 0; k < 16; k++) step();
        check("tmo_valid_early", bus.resp_valid, 0);
        step();
        check("tmo_valid", bus.resp_valid, 1);
        check("tmo_err", bus.resp_err, 1);
        step();
`endif

        check("gnt_queue_empty", exp_gnt.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
